edge_detection_window: RTL and testbench
========================================

Name: edge_detection_window

Overview:
- Parametrised successor to the fixed 16-window edge detector.
- Scans an RGB frame held in single-port SRAM. For each interior pixel it computes a subsampled local average per channel, compares the centre, right and below pixels against average + threshold, and writes one result word per pixel to an output region of the same SRAM.
- Sits on the shared SRAM bus (address/data_read/data_write/wren) alongside the other image-processing stages and is enabled by the top-level sequencer.

Parameters:
- WIDTH, 320: image width in pixels.
- HEIGHT, 240: image height in pixels.
- WINDOW, 16: averaging window edge length; even power of two, >=4.
- STEP, 2: sample stride inside the window; power of two, divides WINDOW.
- ADDR_W, 18: SRAM word-address width.
- IN_BASE, 0: word address of input pixel (0,0).
- OUT_BASE, 76800: word address of output pixel (0,0).
- OUTPUT_MODE, 0: 0 = binary flag word; 1 = debug word carrying the averages.

Ports:
- clk_div_by_two  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- enable_edge_detection  in  1  level run request.
- threshold_red  in  8  noise floor added to the red average.
- threshold_green  in  8  noise floor added to the green average.
- threshold_blue  in  8  noise floor added to the blue average.
- channel_enable  in  3  {blue,green,red}; a 0 excludes that channel from the edge decision.
- data_read  in  32  SRAM read data: red[7:0], green[15:8], blue[31:24]; valid one cycle after address.
- wren  out  1  SRAM write strobe.
- data_write  out  32  SRAM write data.
- address  out  ADDR_W  SRAM word address.
- busy  out  1  high while scanning.
- edge_detection_done  out  1  completion flag.
- edge_count  out  ADDR_W  number of pixels flagged as edges in the current/last run.

Behaviour:
- Reset: wren=0, data_write=0, address=0, busy=0, edge_detection_done=0, edge_count=0, FSM=IDLE.
- Derived values:
  - M = WINDOW/2-1 (margin on every side).
  - K = WINDOW/STEP (samples per axis); N = K*K.
  - Sample offsets, x and y: -M + STEP*i, for i = 0..K-1.
  - Accumulator width: 8 + log2(N).
  - avg = sum >> log2(N) (exact mean).
- Processed pixels: x in [M, WIDTH-1-M], y in [M, HEIGHT-1-M], in raster order. Margin pixels are never written.
- Input address = IN_BASE + y*WIDTH + x. Output address = OUT_BASE + y*WIDTH + x.
- FSM states: IDLE, READ, DECIDE, WRITE, NEXT, DONE.
  - IDLE: when enable_edge_detection=1, latch the thresholds and channel_enable, clear edge_count, set busy=1, go to READ at (M,M).
  - READ: issue 3+N consecutive read addresses, one per cycle: centre, right (x+1), below (y+1), then the window samples y-major. Data arrives one cycle later and is stored or accumulated. The final data lands in the cycle after the last address.
  - DECIDE: per channel, t = avg + threshold, computed at 9 bits with no wrap.
    - If c > t: edge if r < t or b < t.
    - Else: edge if r > t or b > t.
    - flag = OR over enabled channels.
  - WRITE: wren=1 for exactly one cycle with the output address. edge_count increments if flag=1.
    - OUTPUT_MODE=0: data_write = {31'b0, flag}.
    - OUTPUT_MODE=1: data_write = {avg_b, 7'b0, flag, avg_g, avg_r}.
  - NEXT: wren=0; advance x, wrapping to the next row. After the last pixel go to DONE, else READ.
  - Per-pixel cost: N+6 cycles.
  - DONE: busy=0, edge_detection_done=1, held while enable_edge_detection=1. When enable drops, return to IDLE with done=0 on the next cycle.
- Enable dropped mid-run (any state other than DONE): next cycle is IDLE with wren=0, busy=0, done=0, address=0. An in-flight write is cut; at most the current pixel is lost.
- Reset mid-run overrides everything and produces the reset values next cycle.
- wren is never high outside WRITE. No output word is written twice per run.
- Threshold/channel_enable changes during a run are ignored until the next run.

Test Plan:
- Common bench setup: 1-cycle-latency SRAM model, WIDTH=16, HEIGHT=12, WINDOW=4, STEP=2, OUTPUT_MODE=0.
- Uniform image (all 0x40404040), thresholds 0, channel_enable=7 -> 140 writes (x 1..14, y 1..10), all data_write=0, edge_count=0, done rises exactly 1400 cycles (+FSM overhead) after enable.
- Vertical step (red=0 for x<8, red=200 for x>=8, G=B=0), thresholds 0 -> only column x=7 flagged (avg 100, right 200>100), edge_count=10, all other words 0.
- Same image, threshold_red=150 -> t=250, no edges, edge_count=0. Same image with channel_enable=3'b110 -> edge_count=0.
- OUTPUT_MODE=1 on step image -> word at (7,5) equals {8'd0, 7'b0, 1'b1, 8'd0, 8'd100}.
- Drop enable at cycle 300 -> wren=0 and busy=0 next cycle, no further writes. Re-enable -> full 140-pixel run, edge_count restarts at 0.
- Assert reset mid-WRITE -> next cycle all outputs at reset values, FSM in IDLE. No writes occur until enable is sampled high after reset deasserts.

Source files
------------

// File: rtl/edge_detection_window.sv
// Edge detector: windowed subsampled RGB average vs. centre/right/below pixels, results written back to shared SRAM.
// Latency: one start cycle, then N+6 cycles per interior pixel (N = (WINDOW/STEP)^2), one result word each.
// Backpressure: none; SRAM answers every read one cycle later, enable low aborts to IDLE on the next cycle.
module edge_detection_window #(
   parameter int WIDTH       = 320,
   parameter int HEIGHT      = 240,
   parameter int WINDOW      = 16,
   parameter int STEP        = 2,
   parameter int ADDR_W      = 18,
   parameter int IN_BASE     = 0,
   parameter int OUT_BASE    = 76800,
   parameter int OUTPUT_MODE = 0
) (
   input  logic              clk_div_by_two,
   input  logic              reset,
   input  logic              enable_edge_detection,
   input  logic [7:0]        threshold_red,
   input  logic [7:0]        threshold_green,
   input  logic [7:0]        threshold_blue,
   input  logic [2:0]        channel_enable,
   input  logic [31:0]       data_read,
   output logic              wren,
   output logic [31:0]       data_write,
   output logic [ADDR_W-1:0] address,
   output logic              busy,
   output logic              edge_detection_done,
   output logic [ADDR_W-1:0] edge_count
);

   // Window geometry. STEP is assumed smaller than WINDOW so that at least
   // two samples per axis are taken (K >= 2, log2(N) >= 2).
   localparam int M     = WINDOW / 2 - 1;
   localparam int K     = WINDOW / STEP;
   localparam int N     = K * K;
   localparam int LOG2N = $clog2(N);
   localparam int ACC_W = 8 + LOG2N;
   localparam int RW    = $clog2(N + 3);
   localparam int KW    = $clog2(K);
   localparam int XW    = $clog2(WIDTH + 1);
   localparam int YW    = $clog2(HEIGHT + 1);

   localparam logic [ADDR_W-1:0] IN_A       = ADDR_W'(IN_BASE);
   localparam logic [ADDR_W-1:0] OUT_A      = ADDR_W'(OUT_BASE);
   localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] WIDTH_A    = ADDR_W'(WIDTH);
   localparam logic [ADDR_W-1:0] STEP_A     = ADDR_W'(STEP);
   // Offset of pixel (M,M), also the distance from a pixel to its window corner.
   localparam logic [ADDR_W-1:0] CORNER_A   = ADDR_W'(M * WIDTH + M);
   // Jump from the last processed pixel of a row to the first of the next.
   localparam logic [ADDR_W-1:0] ROW_WRAP_A = ADDR_W'(2 * M + 1);
   // Jump from the last sample of a window row to the first of the next.
   localparam logic [ADDR_W-1:0] SAMP_ROW_A = ADDR_W'(STEP * WIDTH - (K - 1) * STEP);

   localparam logic [XW-1:0] X_FIRST   = XW'(M);
   localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1 - M);
   localparam logic [YW-1:0] Y_FIRST   = YW'(M);
   localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1 - M);
   localparam logic [RW-1:0] RIDX_LAST = RW'(N + 2);
   localparam logic [KW-1:0] SX_LAST   = KW'(K - 1);

   typedef struct packed {
      logic [7:0] b;
      logic [7:0] g;
      logic [7:0] r;
   } rgb_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      READ   = 3'd1,
      DECIDE = 3'd2,
      WRITE  = 3'd3,
      NEXT   = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t            state;
   state_t            nstate;

   rgb_t              thr;
   logic [2:0]        ch_en;

   logic [XW-1:0]     px;
   logic [YW-1:0]     py;
   logic [ADDR_W-1:0] pix_off;
   logic [ADDR_W-1:0] samp_off;
   logic [RW-1:0]     ridx;
   logic [KW-1:0]     sx;

   logic              pend_vld;
   logic [RW-1:0]     pend_idx;
   rgb_t              rd_pix;
   rgb_t              ctr_px;
   rgb_t              rgt_px;
   rgb_t              blw_px;
   logic [ACC_W-1:0]  acc_r;
   logic [ACC_W-1:0]  acc_g;
   logic [ACC_W-1:0]  acc_b;

   rgb_t              avg;
   logic              edge_r;
   logic              edge_g;
   logic              edge_b;
   logic              flag;
   logic [31:0]       result_word;
   logic [ADDR_W-1:0] rd_addr;
   logic              last_pix;
   logic              unused_bits;

   assign rd_pix      = {data_read[31:24], data_read[15:8], data_read[7:0]};
   assign unused_bits = ^{data_read[23:16], acc_r[LOG2N-1:0], acc_g[LOG2N-1:0], acc_b[LOG2N-1:0]};
   assign last_pix    = (px == X_LAST) && (py == Y_LAST);

   // One channel's decision: threshold is taken at 9 bits so avg+threshold never wraps.
   function automatic logic chan_edge(input logic [7:0] c, input logic [7:0] r,
                                      input logic [7:0] b, input logic [7:0] a,
                                      input logic [7:0] t8);
      logic [8:0] t;
      t = {1'b0, a} + {1'b0, t8};
      if ({1'b0, c} > t) chan_edge = ({1'b0, r} < t) || ({1'b0, b} < t);
      else               chan_edge = ({1'b0, r} > t) || ({1'b0, b} > t);
   endfunction

   // State register.
   always_ff @(posedge clk_div_by_two) begin
      if (reset) state <= IDLE;
      else       state <= nstate;
   end

   // Next-state logic; enable low from any state returns to IDLE.
   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (enable_edge_detection) nstate = READ;
         READ:    if (!enable_edge_detection) nstate = IDLE;
                  else if (ridx == RIDX_LAST) nstate = DECIDE;
         DECIDE:  nstate = enable_edge_detection ? WRITE : IDLE;
         WRITE:   nstate = enable_edge_detection ? NEXT : IDLE;
         NEXT:    if (!enable_edge_detection) nstate = IDLE;
                  else if (last_pix) nstate = DONE;
                  else nstate = READ;
         DONE:    if (!enable_edge_detection) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // Bus outputs are pure functions of state so abort and reset clear them on the next cycle.
   always_comb begin
      wren                = 1'b0;
      data_write          = '0;
      address             = '0;
      busy                = 1'b0;
      edge_detection_done = 1'b0;
      case (state)
         READ: begin
            busy    = 1'b1;
            address = rd_addr;
         end
         DECIDE, NEXT: busy = 1'b1;
         WRITE: begin
            busy       = 1'b1;
            wren       = 1'b1;
            address    = OUT_A + pix_off;
            data_write = result_word;
         end
         DONE:    edge_detection_done = 1'b1;
         default: ;
      endcase
   end

   // Read address for the current slot: centre, right, below, then window samples.
   always_comb begin
      case (ridx)
         RW'(0):  rd_addr = IN_A + pix_off;
         RW'(1):  rd_addr = IN_A + pix_off + ONE_A;
         RW'(2):  rd_addr = IN_A + pix_off + WIDTH_A;
         default: rd_addr = IN_A + samp_off;
      endcase
   end

   // Averages, per-channel decisions and the result word, all from registered captures.
   always_comb begin
      avg.r  = acc_r[LOG2N +: 8];
      avg.g  = acc_g[LOG2N +: 8];
      avg.b  = acc_b[LOG2N +: 8];
      edge_r = chan_edge(ctr_px.r, rgt_px.r, blw_px.r, avg.r, thr.r);
      edge_g = chan_edge(ctr_px.g, rgt_px.g, blw_px.g, avg.g, thr.g);
      edge_b = chan_edge(ctr_px.b, rgt_px.b, blw_px.b, avg.b, thr.b);
      flag   = (ch_en[0] & edge_r) | (ch_en[1] & edge_g) | (ch_en[2] & edge_b);
      if (OUTPUT_MODE == 1) result_word = {avg.b, 7'b0, flag, avg.g, avg.r};
      else                  result_word = {31'b0, flag};
   end

   // Run configuration and edge counter: latched at start, counted on each flagged write.
   always_ff @(posedge clk_div_by_two) begin
      if (reset) begin
         thr        <= '0;
         ch_en      <= '0;
         edge_count <= '0;
      end else if (state == IDLE && enable_edge_detection) begin
         thr        <= {threshold_blue, threshold_green, threshold_red};
         ch_en      <= channel_enable;
         edge_count <= '0;
      end else if (state == WRITE && flag) begin
         edge_count <= edge_count + ONE_A;
      end
   end

   // Scan position and read sequencing.
   always_ff @(posedge clk_div_by_two) begin
      if (reset) begin
         px       <= '0;
         py       <= '0;
         pix_off  <= '0;
         samp_off <= '0;
         ridx     <= '0;
         sx       <= '0;
      end else begin
         case (state)
            IDLE: begin
               px      <= X_FIRST;
               py      <= Y_FIRST;
               pix_off <= CORNER_A;
               ridx    <= '0;
               sx      <= '0;
            end
            READ: begin
               ridx <= ridx + RW'(1);
               // The window corner is set up while 'below' is being read.
               if (ridx == RW'(2)) samp_off <= pix_off - CORNER_A;
               if (ridx >= RW'(3)) begin
                  if (sx == SX_LAST) begin
                     sx       <= '0;
                     samp_off <= samp_off + SAMP_ROW_A;
                  end else begin
                     sx       <= sx + KW'(1);
                     samp_off <= samp_off + STEP_A;
                  end
               end
            end
            NEXT: begin
               ridx <= '0;
               sx   <= '0;
               if (px == X_LAST) begin
                  px      <= X_FIRST;
                  py      <= py + YW'(1);
                  pix_off <= pix_off + ROW_WRAP_A;
               end else begin
                  px      <= px + XW'(1);
                  pix_off <= pix_off + ONE_A;
               end
            end
            default: ;
         endcase
      end
   end

   // Read-data capture: each word lands one cycle after its address, tagged by the slot index.
   always_ff @(posedge clk_div_by_two) begin
      if (reset) begin
         pend_vld <= 1'b0;
         pend_idx <= '0;
         ctr_px   <= '0;
         rgt_px   <= '0;
         blw_px   <= '0;
         acc_r    <= '0;
         acc_g    <= '0;
         acc_b    <= '0;
      end else begin
         pend_vld <= (state == READ);
         pend_idx <= ridx;
         if (state == READ && ridx == RW'(0)) begin
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
         end else if (pend_vld) begin
            case (pend_idx)
               RW'(0): ctr_px <= rd_pix;
               RW'(1): rgt_px <= rd_pix;
               RW'(2): blw_px <= rd_pix;
               default: begin
                  acc_r <= acc_r + ACC_W'(rd_pix.r);
                  acc_g <= acc_g + ACC_W'(rd_pix.g);
                  acc_b <= acc_b + ACC_W'(rd_pix.b);
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_edge_detection_window.sv
// Bench for edge_detection_window on a 16x12 frame, 4-pixel window, stride 2.
// Expected write words are queued at stimulus time; monitors pop and compare on every wren.
// Input pixels come from a pattern function; a registered read gives one-cycle SRAM latency.
module tb_edge_detection_window;

   localparam int W  = 16;
   localparam int H  = 12;
   localparam int AW = 10;
   localparam int OB = W * H;

   logic          clk;
   logic          reset;
   logic          enable0, enable1;
   logic [7:0]    thr_r, thr_g, thr_b;
   logic [2:0]    ch_en;
   logic [31:0]   rd0, rd1;
   logic          wren0, wren1;
   logic [31:0]   wd0, wd1;
   logic [AW-1:0] addr0, addr1;
   logic          busy0, busy1;
   logic          done0, done1;
   logic [AW-1:0] ecnt0, ecnt1;

   int img_sel;
   int checks;
   int errors;
   int n0_writes;
   int n1_writes;
   logic [AW+31:0] q0[$];
   logic [AW+31:0] q1[$];

   edge_detection_window #(
      .WIDTH(W), .HEIGHT(H), .WINDOW(4), .STEP(2), .ADDR_W(AW),
      .IN_BASE(0), .OUT_BASE(OB), .OUTPUT_MODE(0)
   ) dut (
      .clk_div_by_two(clk), .reset(reset), .enable_edge_detection(enable0),
      .threshold_red(thr_r), .threshold_green(thr_g), .threshold_blue(thr_b),
      .channel_enable(ch_en), .data_read(rd0), .wren(wren0), .data_write(wd0),
      .address(addr0), .busy(busy0), .edge_detection_done(done0), .edge_count(ecnt0)
   );

   edge_detection_window #(
      .WIDTH(W), .HEIGHT(H), .WINDOW(4), .STEP(2), .ADDR_W(AW),
      .IN_BASE(0), .OUT_BASE(OB), .OUTPUT_MODE(1)
   ) dut_dbg (
      .clk_div_by_two(clk), .reset(reset), .enable_edge_detection(enable1),
      .threshold_red(thr_r), .threshold_green(thr_g), .threshold_blue(thr_b),
      .channel_enable(ch_en), .data_read(rd1), .wren(wren1), .data_write(wd1),
      .address(addr1), .busy(busy1), .edge_detection_done(done1), .edge_count(ecnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Input frame: 0 = uniform grey, 1 = red step at x=8. Output region reads as 0.
   function automatic logic [31:0] img_pixel(input int sel, input logic [AW-1:0] a);
      int x;
      if (int'(a) >= OB) return 32'h0;
      x = int'(a) % W;
      if (sel == 0) return 32'h40404040;
      return (x < 8) ? 32'h0 : 32'd200;
   endfunction

   // SRAM read ports with one-cycle latency.
   always @(posedge clk) begin
      rd0 <= img_pixel(img_sel, addr0);
      rd1 <= img_pixel(img_sel, addr1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitors: every write strobe must match the next queued word.
   always @(negedge clk) begin
      if (wren0) begin
         n0_writes++;
         chk("dut0 write expected", 64'(q0.size() != 0), 64'd1);
         if (q0.size() != 0) chk("dut0 write addr/data", 64'({addr0, wd0}), 64'(q0.pop_front()));
      end
      if (wren1) begin
         n1_writes++;
         chk("dbg write expected", 64'(q1.size() != 0), 64'd1);
         if (q1.size() != 0) chk("dbg write addr/data", 64'({addr1, wd1}), 64'(q1.pop_front()));
      end
   end

   // Binary-mode words: only column flag_col is flagged (none if -1).
   task automatic push_mode0(input int flag_col);
      for (int y = 1; y <= H - 2; y++)
         for (int x = 1; x <= W - 2; x++)
            q0.push_back({AW'(OB + y * W + x), 31'b0, (x == flag_col)});
   endtask

   // Debug words for the step image: red averages 0 / 100 / 200, flag at x=7.
   task automatic push_mode1_step();
      logic [7:0] av;
      for (int y = 1; y <= H - 2; y++)
         for (int x = 1; x <= W - 2; x++) begin
            av = (x <= 6) ? 8'd0 : (x <= 8) ? 8'd100 : 8'd200;
            q1.push_back({AW'(OB + y * W + x), 8'd0, 7'b0, (x == 7), 8'd0, av});
         end
   endtask

   // Full run on the binary-mode DUT; caller is at a negedge.
   task automatic run_dut0(input int exp_cnt);
      int cyc;
      enable0 = 1'b1;
      @(negedge clk);
      cyc = 1;
      chk("busy after start", 64'(busy0), 64'd1);
      chk("edge_count cleared at start", 64'(ecnt0), 64'd0);
      while (!done0 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      chk("done latency cycles", 64'(cyc), 64'd1401);
      chk("edge_count at done", 64'(ecnt0), 64'(exp_cnt));
      chk("all writes seen", 64'(q0.size()), 64'd0);
      chk("busy low in done", 64'(busy0), 64'd0);
      repeat (3) @(negedge clk);
      chk("done held while enabled", 64'(done0), 64'd1);
      enable0 = 1'b0;
      @(negedge clk);
      chk("done cleared after enable drop", 64'(done0), 64'd0);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " wren"}, 64'(wren0), 64'd0);
      chk({tag, " data_write"}, 64'(wd0), 64'd0);
      chk({tag, " address"}, 64'(addr0), 64'd0);
      chk({tag, " busy"}, 64'(busy0), 64'd0);
      chk({tag, " done"}, 64'(done0), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int popped, nb, guard, wseen, cyc;
      checks = 0; errors = 0; n0_writes = 0; n1_writes = 0;
      img_sel = 0;
      reset = 1'b1; enable0 = 1'b0; enable1 = 1'b0;
      thr_r = 8'd0; thr_g = 8'd0; thr_b = 8'd0; ch_en = 3'b111;
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset");
      chk("reset edge_count", 64'(ecnt0), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // Uniform image: no edges anywhere.
      img_sel = 0;
      push_mode0(-1);
      run_dut0(0);

      // Red step: only column 7 flagged.
      img_sel = 1;
      push_mode0(7);
      run_dut0(10);

      // Red threshold raises t to 250: nothing flagged.
      thr_r = 8'd150;
      push_mode0(-1);
      run_dut0(0);
      thr_r = 8'd0;

      // Red channel excluded.
      ch_en = 3'b110;
      push_mode0(-1);
      run_dut0(0);
      ch_en = 3'b111;

      // Debug-word DUT on the step image.
      push_mode1_step();
      enable1 = 1'b1;
      cyc = 0;
      while (!done1 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      chk("dbg done latency cycles", 64'(cyc), 64'd1401);
      chk("dbg edge_count", 64'(ecnt1), 64'd10);
      chk("dbg all writes seen", 64'(q1.size()), 64'd0);
      enable1 = 1'b0;
      @(negedge clk);

      // Abort after 300 cycles, then a clean full rerun.
      push_mode0(7);
      enable0 = 1'b1;
      repeat (300) @(negedge clk);
      thr_r = 8'd255;
      ch_en = 3'b000;
      enable0 = 1'b0;
      @(negedge clk);
      chk_idle_outputs("abort");
      popped = (H - 2) * (W - 2) - q0.size();
      chk("abort writes in 29..31", 64'(popped >= 29 && popped <= 31), 64'd1);
      chk("abort edge_count", 64'(ecnt0), 64'd2);
      nb = n0_writes;
      repeat (40) @(negedge clk);
      chk("no writes after abort", 64'(n0_writes - nb), 64'd0);
      q0.delete();
      thr_r = 8'd0;
      ch_en = 3'b111;
      push_mode0(7);
      run_dut0(10);

      // Reset asserted during the third WRITE cycle.
      push_mode0(7);
      enable0 = 1'b1;
      wseen = 0;
      guard = 0;
      while (wseen < 3 && guard < 200) begin
         @(negedge clk);
         guard++;
         if (wren0) wseen++;
      end
      chk("reached third write", 64'(wseen), 64'd3);
      reset = 1'b1;
      enable0 = 1'b0;
      @(negedge clk);
      chk_idle_outputs("mid-write reset");
      chk("mid-write reset edge_count", 64'(ecnt0), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      nb = n0_writes;
      repeat (30) @(negedge clk);
      chk("no writes after reset", 64'(n0_writes - nb), 64'd0);
      chk("idle busy after reset", 64'(busy0), 64'd0);
      q0.delete();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
